// File: rtl/pigro_pkg.sv
// Shared pigro ISA definitions: opcode encodings, instruction
// field positions and the register-write predicate.
package pigro_pkg;

    localparam int INSTR_W   = 32;
    localparam int OP_W      = 5;
    localparam int OP_LSB    = 27;
    localparam int IMMF_BIT  = 26;
    localparam int RD_LSB    = 22;
    localparam int RA_LSB    = 18;
    localparam int RB_LSB    = 14;
    localparam int IMM_LSB   = 0;
    localparam int DISPL_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 5'd0,
        OP_JMP = 5'd1,
        OP_STR = 5'd2,
        OP_ADD = 5'd3,
        OP_SUB = 5'd4,
        OP_AND = 5'd5,
        OP_OR  = 5'd6,
        OP_LD  = 5'd7
    } opcode_e;

    function automatic logic writes_reg(input logic [OP_W-1:0] op);
        return !(op == OP_NOP || op == OP_JMP || op == OP_STR);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writers;
// flags a RAW hazard against the decoding instruction's sources.
module hazard_scoreboard #(
    parameter int NSTAGE = 3,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_shift,
    input  logic          i_ins_valid,
    input  logic [AW-1:0] i_ins_addr,
    input  logic [AW-1:0] i_ra,
    input  logic [AW-1:0] i_rb,
    input  logic          i_rb_en,
    output logic          o_raw
);

    logic [NSTAGE-1:0] r_vld;
    logic [AW-1:0]     r_addr [NSTAGE];

    // Age entries one slot per advancing cycle; newest writer enters slot 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                r_addr[i] <= '0;
            end
        end else if (i_shift) begin
            r_vld[0]  <= i_ins_valid;
            r_addr[0] <= i_ins_addr;
            for (int i = 1; i < NSTAGE; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    // Any live writer matching a used source operand is a hazard
    always_comb begin
        o_raw = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (r_vld[i] && (r_addr[i] == i_ra ||
                (i_rb_en && r_addr[i] == i_rb))) begin
                o_raw = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode stage: one-entry decode register, RAW stall against
// in-flight writers, in-decode jump resolution, registered issue.
module decode_scoreboard
    import pigro_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 16,
    parameter int PCW    = 5,
    parameter int NSTAGE = 3,
    parameter int IMMW   = 18,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_in,
    input  logic [PCW-1:0]  pc_in,
    output logic [AW-1:0]   addr_a_rf,
    output logic [AW-1:0]   addr_b_rf,
    input  logic [XLEN-1:0] data_a_rf,
    input  logic [XLEN-1:0] data_b_rf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      opcode,
    output logic [XLEN-1:0] data_a,
    output logic [XLEN-1:0] data_b,
    output logic [XLEN-1:0] immediate,
    output logic            isimmediate,
    output logic [AW-1:0]   dest_addr,
    output logic [AW-1:0]   o_addr_a,
    output logic [PCW-1:0]  pc,
    output logic            jump_flag,
    output logic [PCW-1:0]  jump_dest,
    output logic            stall
);

    logic                r_dvalid;
    logic [INSTR_W-1:0]  r_instr;
    logic [PCW-1:0]      r_pc;

    logic [OP_W-1:0]     w_op;
    logic                w_immf;
    logic [AW-1:0]       w_rd;
    logic [AW-1:0]       w_ra;
    logic [AW-1:0]       w_rb;
    logic [IMMW-1:0]     w_imm;
    logic [PCW-1:0]      w_displ;
    logic [XLEN-1:0]     w_imm_ext;
    logic                w_is_jmp;
    logic                w_raw;
    logic                w_jump;
    logic                w_issue;
    logic                w_accept;

    assign w_op      = r_instr[OP_LSB +: OP_W];
    assign w_immf    = r_instr[IMMF_BIT];
    assign w_rd      = r_instr[RD_LSB +: AW];
    assign w_ra      = r_instr[RA_LSB +: AW];
    assign w_rb      = r_instr[RB_LSB +: AW];
    assign w_imm     = r_instr[IMM_LSB +: IMMW];
    assign w_displ   = r_instr[DISPL_LSB +: PCW];
    assign w_imm_ext = {{(XLEN-IMMW){w_imm[IMMW-1]}}, w_imm};
    assign w_is_jmp  = (w_op == OP_JMP);

    // A jump is consumed in decode and never reaches execute;
    // held off during reset so a discarded JMP cannot redirect.
    assign w_jump   = rst & r_dvalid & w_is_jmp & ~w_raw & out_ready;
    assign w_issue  = r_dvalid & ~w_raw & out_ready & ~w_is_jmp;
    assign in_ready = ~r_dvalid | w_issue;
    assign w_accept = in_valid & in_ready;

    assign addr_a_rf = w_ra;
    assign addr_b_rf = w_rb;
    assign stall     = w_raw & r_dvalid;
    assign jump_flag = w_jump;
    assign jump_dest = w_immf ? w_displ : r_pc + w_displ;

    hazard_scoreboard #(
        .NSTAGE (NSTAGE),
        .AW     (AW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_shift     (out_ready),
        .i_ins_valid (w_issue & writes_reg(w_op)),
        .i_ins_addr  (w_rd),
        .i_ra        (w_ra),
        .i_rb        (w_rb),
        .i_rb_en     (~w_immf),
        .o_raw       (w_raw)
    );

    // Decode register: refill on accept, empty on issue or jump
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dvalid <= 1'b0;
            r_instr  <= '0;
            r_pc     <= '0;
        end else if (w_accept) begin
            r_dvalid <= 1'b1;
            r_instr  <= instr_in;
            r_pc     <= pc_in;
        end else if (w_issue || w_jump) begin
            r_dvalid <= 1'b0;
        end
    end

    // Issue register: load on issue, bubble when advancing idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            opcode      <= OP_NOP;
            data_a      <= '0;
            data_b      <= '0;
            immediate   <= '0;
            isimmediate <= 1'b0;
            dest_addr   <= '0;
            o_addr_a    <= '0;
            pc          <= '0;
        end else if (w_issue) begin
            out_valid   <= 1'b1;
            opcode      <= w_op;
            data_a      <= data_a_rf;
            data_b      <= w_immf ? '0 : data_b_rf;
            immediate   <= w_immf ? w_imm_ext : '0;
            isimmediate <= w_immf;
            dest_addr   <= w_rd;
            o_addr_a    <= w_ra;
            pc          <= r_pc;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
            opcode      <= OP_NOP;
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed scenarios plus random
// traffic against a time-based hazard reference model.
module tb_decode_scoreboard;

    localparam int XLEN   = 32;
    localparam int NREG   = 16;
    localparam int PCW    = 5;
    localparam int NSTAGE = 3;
    localparam int IMMW   = 18;
    localparam int AW     = 4;

    localparam logic [4:0] NOP = 5'd0;
    localparam logic [4:0] JMP = 5'd1;
    localparam logic [4:0] STR = 5'd2;
    localparam logic [4:0] ADD = 5'd3;
    localparam logic [4:0] SUB = 5'd4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     instr_in = '0;
    logic [PCW-1:0]  pc_in = '0;
    logic [AW-1:0]   addr_a_rf, addr_b_rf;
    logic [XLEN-1:0] data_a_rf, data_b_rf;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [4:0]      opcode;
    logic [XLEN-1:0] data_a, data_b, immediate;
    logic            isimmediate;
    logic [AW-1:0]   dest_addr, o_addr_a;
    logic [PCW-1:0]  pc;
    logic            jump_flag;
    logic [PCW-1:0]  jump_dest;
    logic            stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rfa(input logic [3:0] a);
        return 32'hC0DE_0000 | {28'h0, a};
    endfunction

    function automatic logic [31:0] rfb(input logic [3:0] a);
        return 32'h5EED_0000 | {28'h0, a};
    endfunction

    assign data_a_rf = rfa(addr_a_rf);
    assign data_b_rf = rfb(addr_b_rf);

    decode_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .PCW(PCW),
        .NSTAGE(NSTAGE), .IMMW(IMMW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in),
        .addr_a_rf(addr_a_rf), .addr_b_rf(addr_b_rf),
        .data_a_rf(data_a_rf), .data_b_rf(data_b_rf),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .data_a(data_a), .data_b(data_b),
        .immediate(immediate), .isimmediate(isimmediate),
        .dest_addr(dest_addr), .o_addr_a(o_addr_a), .pc(pc),
        .jump_flag(jump_flag), .jump_dest(jump_dest),
        .stall(stall)
    );

    function automatic logic [31:0] mk_r(input logic [4:0] op,
        input logic [3:0] rd, input logic [3:0] ra,
        input logic [3:0] rb);
        return {op, 1'b0, rd, ra, rb, 14'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op,
        input logic [3:0] rd, input logic [3:0] ra,
        input logic [17:0] imm);
        return {op, 1'b1, rd, ra, imm};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins,
        input logic [PCW-1:0] p, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        instr_in  = ins;
        pc_in     = p;
        out_ready = ordy;
    endtask

    task automatic drain(input int n);
        repeat (n) drive(1'b0, 32'h0, '0, 1'b1);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        instr_in = mk_r(ADD, 4'd1, 4'd2, 4'd3);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (opcode !== NOP) begin
            errors++;
            $display("FAIL rst_opcode got %h exp %h", opcode, NOP);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got %b exp 1", in_ready);
        end
        checks++;
        if ({data_a, data_b, immediate, dest_addr, o_addr_a, pc}
            !== '0) begin
            errors++;
            $display("FAIL rst_data got %h %h %h %h %h %h exp 0",
                data_a, data_b, immediate, dest_addr, o_addr_a, pc);
        end
        checks++;
        if ({stall, jump_flag} !== 2'b00) begin
            errors++;
            $display("FAIL rst_flags got %b%b exp 00",
                stall, jump_flag);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, mk_r(ADD, 4'd9, 4'd0, 4'd0), 5'd2, 1'b1);
        drive(1'b1, {JMP, 1'b1, 4'd0, 4'd0, 18'd7}, 5'd3, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (jump_flag !== 1'b0) begin
            errors++;
            $display("FAIL midrst_jump got %b exp 0", jump_flag);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        instr_in = mk_r(ADD, 4'd1, 4'd9, 4'd9);
        #1;
        checks++;
        if ({jump_flag, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_flags got %b%b exp 01",
                jump_flag, in_ready);
        end
        drive(1'b0, 32'h0, '0, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stall got %b exp 0", stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || dest_addr !== 4'd1) begin
            errors++;
            $display("FAIL midrst_issue got %b/%h exp 1/1",
                out_valid, dest_addr);
        end
        drain(5);
    endtask

    task automatic test_back_to_back;
        drive(1'b1, mk_r(ADD, 4'd1, 4'd2, 4'd3), 5'd8, 1'b1);
        drive(1'b1, mk_r(ADD, 4'd4, 4'd5, 4'd6), 5'd9, 1'b1);
        #1;
        checks++;
        if ({stall, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_first got %b%b exp 01",
                stall, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || opcode !== ADD ||
            dest_addr !== 4'd1 || o_addr_a !== 4'd2 ||
            data_a !== rfa(4'd2) || data_b !== rfb(4'd3) ||
            pc !== 5'd8) begin
            errors++;
            $display("FAIL b2b_op1 got %b %h %h %h %h %h %h",
                out_valid, opcode, dest_addr, o_addr_a,
                data_a, data_b, pc);
        end
        drive(1'b0, 32'h0, '0, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall got %b exp 0", stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || dest_addr !== 4'd4 ||
            data_a !== rfa(4'd5) || data_b !== rfb(4'd6) ||
            pc !== 5'd9) begin
            errors++;
            $display("FAIL b2b_op2 got %b %h %h %h %h",
                out_valid, dest_addr, data_a, data_b, pc);
        end
        drain(5);
    endtask

    task automatic test_raw(input int hold);
        int nst, nb, at;
        nst = 0;
        nb = 0;
        at = 0;
        drive(1'b1, mk_r(ADD, 4'd1, 4'd2, 4'd3), 5'd4, 1'b1);
        drive(1'b1, mk_r(ADD, 4'd4, 4'd1, 4'd5), 5'd5, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || dest_addr !== 4'd1) begin
            errors++;
            $display("FAIL raw_first got %b/%h exp 1/1",
                out_valid, dest_addr);
        end
        for (int k = 0; k < hold; k++) begin
            drive(1'b0, 32'h0, '0, 1'b0);
            #1;
            checks++;
            if ({stall, in_ready} !== 2'b10) begin
                errors++;
                $display("FAIL bp_stall[%0d] got %b%b exp 10",
                    k, stall, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || dest_addr !== 4'd1 ||
                opcode !== ADD || data_a !== rfa(4'd2)) begin
                errors++;
                $display("FAIL bp_frozen[%0d] got %b %h %h %h",
                    k, out_valid, dest_addr, opcode, data_a);
            end
        end
        for (int k = 1; k <= 10 && at == 0; k++) begin
            drive(1'b0, 32'h0, '0, 1'b1);
            #1;
            if (k == 1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL raw_in_ready got %b exp 0",
                        in_ready);
                end
            end
            if (stall === 1'b1) nst++;
            @(posedge clk);
            #1;
            if (out_valid === 1'b1 && dest_addr === 4'd4)
                at = k;
            else if (out_valid === 1'b0 && opcode === NOP)
                nb++;
        end
        checks++;
        if (nst != 3) begin
            errors++;
            $display("FAIL raw_stall_cycles got %0d exp 3", nst);
        end
        checks++;
        if (nb != 3) begin
            errors++;
            $display("FAIL raw_bubbles got %0d exp 3", nb);
        end
        checks++;
        if (at != 4) begin
            errors++;
            $display("FAIL raw_issue_edge got %0d exp 4", at);
        end
        checks++;
        if (data_a !== rfa(4'd1) || pc !== 5'd5) begin
            errors++;
            $display("FAIL raw_op2 got %h/%h exp %h/05",
                data_a, pc, rfa(4'd1));
        end
        drain(5);
    endtask

    task automatic test_immediate;
        drive(1'b1, mk_r(ADD, 4'd15, 4'd2, 4'd3), 5'd0, 1'b1);
        drive(1'b1, mk_i(ADD, 4'd10, 4'd2, 18'h3FFFE), 5'd1, 1'b1);
        @(posedge clk);
        drive(1'b0, 32'h0, '0, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL imm_rb_ignored got %b exp 0", stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || dest_addr !== 4'd10 ||
            isimmediate !== 1'b1) begin
            errors++;
            $display("FAIL imm_issue got %b %h %b",
                out_valid, dest_addr, isimmediate);
        end
        checks++;
        if (immediate !== 32'hFFFF_FFFE || data_b !== 32'h0 ||
            data_a !== rfa(4'd2)) begin
            errors++;
            $display("FAIL imm_values got %h %h %h",
                immediate, data_b, data_a);
        end
        drain(5);
    endtask

    task automatic test_jump;
        int jat, jcnt, nst;
        drive(1'b1, {JMP, 1'b0, 4'd6, 4'd0, 18'd5}, 5'd30, 1'b1);
        drive(1'b0, 32'h0, '0, 1'b1);
        #1;
        checks++;
        if ({jump_flag, in_ready, stall} !== 3'b100 ||
            jump_dest !== 5'd3) begin
            errors++;
            $display("FAIL jmp_rel got %b%b%b dest %0d exp 100/3",
                jump_flag, in_ready, stall, jump_dest);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || opcode !== NOP) begin
            errors++;
            $display("FAIL jmp_bubble got %b/%h exp 0/00",
                out_valid, opcode);
        end
        drive(1'b1, mk_r(ADD, 4'd1, 4'd6, 4'd6), 5'd0, 1'b1);
        #1;
        checks++;
        if ({jump_flag, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL jmp_pulse got %b%b exp 01",
                jump_flag, in_ready);
        end
        drive(1'b1, {JMP, 1'b1, 4'd0, 4'd0, 18'd9}, 5'd30, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL jmp_no_entry got %b exp 0", stall);
        end
        drive(1'b0, 32'h0, '0, 1'b1);
        #1;
        checks++;
        if (jump_flag !== 1'b1 || jump_dest !== 5'd9) begin
            errors++;
            $display("FAIL jmp_abs got %b/%0d exp 1/9",
                jump_flag, jump_dest);
        end
        drain(5);
        jat = 0;
        jcnt = 0;
        nst = 0;
        drive(1'b1, mk_r(ADD, 4'd3, 4'd0, 4'd0), 5'd0, 1'b1);
        drive(1'b1, {JMP, 1'b1, 4'd0, 4'd3, 18'd7}, 5'd1, 1'b1);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 32'h0, '0, 1'b1);
            #1;
            if (stall === 1'b1) nst++;
            if (jump_flag === 1'b1) begin
                jcnt++;
                if (jat == 0) jat = k;
            end
        end
        checks++;
        if (jat != 4 || jcnt != 1 || nst != 3) begin
            errors++;
            $display("FAIL jmp_hazard got at %0d n %0d st %0d",
                jat, jcnt, nst);
        end
        drain(5);
    endtask

    task automatic test_random;
        logic        m_dv;
        logic [31:0] m_ins;
        logic [4:0]  m_pc;
        int          tick;
        int          clr[16];
        logic        e_ov, e_ii;
        logic [4:0]  e_op, e_pc;
        logic [31:0] e_da, e_db, e_im;
        logic [3:0]  e_rd, e_ra;
        logic [4:0]  op, jd;
        logic [3:0]  ra, rb, rd;
        logic        im, haz, s_e, j_e, i_e, r_e;
        logic [4:0]  ops [5];
        ops = '{NOP, JMP, STR, ADD, SUB};
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        m_dv = 1'b0;
        m_ins = '0;
        m_pc = '0;
        tick = 0;
        foreach (clr[i]) clr[i] = 0;
        e_ov = 1'b0;
        e_op = NOP;
        e_ii = 1'b0;
        e_pc = '0;
        e_da = '0;
        e_db = '0;
        e_im = '0;
        e_rd = '0;
        e_ra = '0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            rst = 1'b1;
            in_valid = ($urandom_range(0, 3) != 0);
            instr_in = {ops[$urandom_range(0, 4)], 27'($urandom)};
            pc_in = 5'($urandom);
            out_ready = ($urandom_range(0, 4) != 0);
            #1;
            op = m_ins[31:27];
            im = m_ins[26];
            rd = m_ins[25:22];
            ra = m_ins[21:18];
            rb = m_ins[17:14];
            haz = (tick < clr[ra]) || (!im && tick < clr[rb]);
            s_e = m_dv && haz;
            j_e = m_dv && op == JMP && !haz && out_ready;
            i_e = m_dv && op != JMP && !haz && out_ready;
            r_e = !m_dv || i_e;
            jd = im ? m_ins[4:0] : m_pc + m_ins[4:0];
            checks++;
            if ({in_ready, stall, jump_flag} !== {r_e, s_e, j_e}) begin
                errors++;
                $display("FAIL rnd_flags[%0d] got %b%b%b exp %b%b%b",
                    n, in_ready, stall, jump_flag, r_e, s_e, j_e);
            end
            checks++;
            if (addr_a_rf !== ra || addr_b_rf !== rb) begin
                errors++;
                $display("FAIL rnd_rfaddr[%0d] got %h/%h exp %h/%h",
                    n, addr_a_rf, addr_b_rf, ra, rb);
            end
            if (j_e) begin
                checks++;
                if (jump_dest !== jd) begin
                    errors++;
                    $display("FAIL rnd_jdest[%0d] got %0d exp %0d",
                        n, jump_dest, jd);
                end
            end
            if (i_e) begin
                e_ov = 1'b1;
                e_op = op;
                e_da = rfa(ra);
                e_db = im ? 32'h0 : rfb(rb);
                e_im = im ? {{14{m_ins[17]}}, m_ins[17:0]} : 32'h0;
                e_ii = im;
                e_rd = rd;
                e_ra = ra;
                e_pc = m_pc;
            end else if (out_ready) begin
                e_ov = 1'b0;
                e_op = NOP;
            end
            if (out_ready) tick++;
            if (i_e && !(op inside {NOP, JMP, STR}))
                clr[rd] = tick + NSTAGE;
            if (in_valid && r_e) begin
                m_dv = 1'b1;
                m_ins = instr_in;
                m_pc = pc_in;
            end else if (i_e || j_e) begin
                m_dv = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== e_ov || opcode !== e_op) begin
                errors++;
                $display("FAIL rnd_out[%0d] got %b/%h exp %b/%h",
                    n, out_valid, opcode, e_ov, e_op);
            end
            if (e_ov) begin
                checks++;
                if (data_a !== e_da || data_b !== e_db ||
                    immediate !== e_im || isimmediate !== e_ii) begin
                    errors++;
                    $display("FAIL rnd_data[%0d] got %h %h %h %b",
                        n, data_a, data_b, immediate, isimmediate);
                end
                checks++;
                if (dest_addr !== e_rd || o_addr_a !== e_ra ||
                    pc !== e_pc) begin
                    errors++;
                    $display("FAIL rnd_addr[%0d] got %h %h %h exp %h %h %h",
                        n, dest_addr, o_addr_a, pc, e_rd, e_ra, e_pc);
                end
            end
        end
        drain(5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_raw(0);
        test_immediate();
        test_jump();
        test_raw(4);
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
            checks, errors);
        $finish;
    end

endmodule
